// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access: one transaction at a time,
// anti-starvation for fetch, bounded retry of RAM errors and a sticky fault.
module mem_port_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int RETRY_MAX  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        fault
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int RW = $clog2(RETRY_MAX + 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, FAULT} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   dstreak_reg, dstreak_next;
    logic [RW-1:0]   retry_reg, retry_next;
    logic            fault_reg, fault_next;

    logic            dreq;
    logic            starve;
    logic [RW-1:0]   retry_inc;

    assign dreq      = dREN | dWEN;
    assign starve    = iREN && (dstreak_reg == SW'(STARVE_LIM));
    assign retry_inc = retry_reg + RW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            dstreak_reg <= '0;
            retry_reg   <= '0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dstreak_reg <= dstreak_next;
            retry_reg   <= retry_next;
            fault_reg   <= fault_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dstreak_next = dstreak_reg;
        retry_next   = retry_reg;
        fault_next   = fault_reg;
        case (state_reg)
            IDLE: begin
                if (dreq && !starve) begin
                    state_next = DGRANT;
                    if (!iREN)
                        dstreak_next = '0;
                    else if (dstreak_reg != SW'(STARVE_LIM))
                        dstreak_next = dstreak_reg + SW'(1);
                end else if (iREN) begin
                    state_next   = IGRANT;
                    dstreak_next = '0;
                end else begin
                    dstreak_next = '0;
                end
            end
            IGRANT, DGRANT: begin
                // A dropped request (pipeline flush) abandons the transaction without a hit.
                if ((state_reg == IGRANT) ? !iREN : !dreq) begin
                    state_next = IDLE;
                    retry_next = '0;
                end else if (ramstate == RAM_ACCESS) begin
                    state_next = IDLE;
                    retry_next = '0;
                end else if (ramstate == RAM_ERROR) begin
                    retry_next = retry_inc;
                    if (retry_inc == RW'(RETRY_MAX)) begin
                        state_next = FAULT;
                        fault_next = 1'b1;
                    end
                end
            end
            FAULT: fault_next = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        fault    = fault_reg;
        if (state_reg == IGRANT && iREN) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ramstate == RAM_ACCESS) begin
                ihit  = 1'b1;
                iload = ramload;
            end
        end else if (state_reg == DGRANT && dreq) begin
            // Write takes priority when both enables are raised.
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (ramstate == RAM_ACCESS) begin
                dhit  = 1'b1;
                dload = dWEN ? 32'd0 : ramload;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal checks, plus a per-cycle
// ownership model compared against every output on each falling edge.
module tb_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        fault;

    int checks = 0;
    int passes = 0;

    // Model: who owns the RAM port (0 none, 1 fetch, 2 data, 3 faulted), data grants in a row
    // while fetch waited, and errors seen on the current transaction.
    int m_owner  = 0;
    int m_streak = 0;
    int m_errs   = 0;

    mem_port_arbiter #(.STARVE_LIM(4), .RETRY_MAX(3)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .fault(fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        logic        e_ihit, e_dhit, e_ren, e_wen, e_fault, active;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_fault = 0; active = 0;
        e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
        if (RST) begin
            m_owner = 0; m_streak = 0; m_errs = 0;
        end else begin
            if (m_owner == 1) begin
                active = iREN;
                if (active) begin
                    e_ren = 1; e_addr = iaddr;
                    e_ihit = (ramstate == 2'd2);
                    e_iload = e_ihit ? ramload : 32'd0;
                end
            end else if (m_owner == 2) begin
                active = dREN | dWEN;
                if (active) begin
                    e_wen = dWEN; e_ren = dREN & ~dWEN;
                    e_addr = daddr; e_store = dstore;
                    e_dhit = (ramstate == 2'd2);
                    e_dload = (e_dhit && !dWEN) ? ramload : 32'd0;
                end
            end else if (m_owner == 3) begin
                e_fault = 1;
            end
        end
        chk("model_ihit", {31'd0, ihit}, {31'd0, e_ihit});
        chk("model_dhit", {31'd0, dhit}, {31'd0, e_dhit});
        chk("model_iload", iload, e_iload);
        chk("model_dload", dload, e_dload);
        chk("model_ramREN", {31'd0, ramREN}, {31'd0, e_ren});
        chk("model_ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
        chk("model_ramaddr", ramaddr, e_addr);
        chk("model_ramstore", ramstore, e_store);
        chk("model_fault", {31'd0, fault}, {31'd0, e_fault});
        if (!RST) begin
            if (m_owner == 0) begin
                if ((dREN || dWEN) && !(iREN && m_streak >= 4)) begin
                    m_owner = 2;
                    m_streak = iREN ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
                end else if (iREN) begin
                    m_owner = 1;
                    m_streak = 0;
                end else begin
                    m_streak = 0;
                end
            end else if (m_owner == 1 || m_owner == 2) begin
                if (!active || ramstate == 2'd2) begin
                    m_owner = 0; m_errs = 0;
                end else if (ramstate == 2'd3) begin
                    m_errs++;
                    if (m_errs >= 3) m_owner = 3;
                end
            end
        end
    end

    initial begin
        RST = 1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = 0;
        repeat (2) tick();
        #1;
        chk("reset_ramREN", {31'd0, ramREN}, 32'd0);
        chk("reset_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("reset_loads", iload | dload, 32'd0);
        chk("reset_fault", {31'd0, fault}, 32'd0);
        RST = 0;
        tick();

        // Fetch only, ACCESS two cycles after the grant.
        iREN = 1; iaddr = 32'h40; ramload = 32'h8C220004; ramstate = 2'd0;
        tick();
        ramstate = 2'd1;
        #1;
        chk("fetch_ramREN", {31'd0, ramREN}, 32'd1);
        chk("fetch_ramaddr", ramaddr, 32'h40);
        chk("fetch_no_early_hit", {31'd0, ihit}, 32'd0);
        tick();
        tick();
        ramstate = 2'd2;
        #1;
        chk("fetch_ihit", {31'd0, ihit}, 32'd1);
        chk("fetch_iload", iload, 32'h8C220004);
        tick();
        iREN = 0; ramstate = 2'd0;
        #1;
        chk("fetch_ihit_one_cycle", {31'd0, ihit}, 32'd0);
        tick();

        // Contention: four data grants, then fetch is forced.
        iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h300; ramload = 32'h11110000;
        ramstate = 2'd2;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            if (k < 4) begin
                chk($sformatf("contend_dhit_%0d", k), {30'd0, ihit, dhit}, 32'd1);
                chk($sformatf("contend_dload_%0d", k), dload, 32'h11110000);
            end else begin
                chk("contend_forced_ihit", {30'd0, ihit, dhit}, 32'd2);
                chk("contend_forced_iaddr", ramaddr, 32'h80);
            end
            tick();
        end
        tick();
        #1;
        chk("contend_streak_cleared_dgrant", {30'd0, ihit, dhit}, 32'd1);
        iREN = 0; dREN = 0; ramstate = 2'd0;
        tick();

        // Read+write together: write wins, dload stays 0.
        dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramload = 32'h12345678;
        ramstate = 2'd1;
        tick();
        #1;
        chk("write_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("write_ramREN", {31'd0, ramREN}, 32'd0);
        chk("write_ramstore", ramstore, 32'hDEADBEEF);
        chk("write_ramaddr", ramaddr, 32'h100);
        tick();
        ramstate = 2'd2;
        #1;
        chk("write_dhit", {31'd0, dhit}, 32'd1);
        chk("write_dload_zero", dload, 32'd0);
        tick();
        dREN = 0; dWEN = 0; ramstate = 2'd0;
        tick();

        // Two errors are tolerated; the third raises the sticky fault.
        dREN = 1; daddr = 32'h200; ramload = 32'hCAFEF00D; ramstate = 2'd0;
        tick();
        ramstate = 2'd3;
        tick();
        tick();
        ramstate = 2'd2;
        #1;
        chk("retry_dhit", {31'd0, dhit}, 32'd1);
        chk("retry_dload", dload, 32'hCAFEF00D);
        chk("retry_no_fault", {31'd0, fault}, 32'd0);
        tick();
        dREN = 0; ramstate = 2'd0;
        tick();
        dREN = 1; ramstate = 2'd0;
        tick();
        ramstate = 2'd3;
        repeat (3) tick();
        ramstate = 2'd2;
        #1;
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_ramREN", {31'd0, ramREN}, 32'd0);
        chk("fault_no_dhit", {31'd0, dhit}, 32'd0);
        tick();
        tick();
        RST = 1;
        tick();
        #1;
        chk("fault_cleared_by_reset", {31'd0, fault}, 32'd0);
        RST = 0; dREN = 0; ramstate = 2'd0;
        tick();

        // Flush during BUSY, then reset during a data grant.
        dREN = 1; daddr = 32'h44; ramstate = 2'd1;
        tick();
        #1;
        chk("abort_granted", {31'd0, ramREN}, 32'd1);
        dREN = 0;
        #1;
        chk("abort_ramREN_drop", {31'd0, ramREN}, 32'd0);
        chk("abort_no_dhit", {31'd0, dhit}, 32'd0);
        tick();
        #1;
        chk("abort_idle", {31'd0, ramREN}, 32'd0);
        dREN = 1; dWEN = 1;
        tick();
        #1;
        chk("rst_mid_granted", {31'd0, ramWEN}, 32'd1);
        RST = 1;
        #1;
        chk("rst_mid_enables", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_mid_fault", {31'd0, fault}, 32'd0);
        tick();
        RST = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
